// File: rtl/dot_product_pkg.sv
// Shared types and width helpers for the dot-product MAC.
package dot_product_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} dp_state_t;

    // Result width that cannot overflow: full product width plus log2 of the term count.
    function automatic int acc_width(input int dw, input int depth);
        return 2 * dw + $clog2(depth);
    endfunction

endpackage

// File: rtl/dot_product_mac_mult.sv
// One DW x DW lane multiplier with signed/unsigned mode and a (2*DW+1)-bit product.
module dp_lane_mult #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic          signed_i,
    output logic [2*DW:0] prod_o
);

    logic [2*DW:0] a_x;
    logic [2*DW:0] b_x;

    // Extend both operands to the product width; modular multiply then gives the
    // exact two's-complement product because it always fits in 2*DW+1 bits.
    assign a_x    = {{(DW+1){signed_i & a_i[DW-1]}}, a_i};
    assign b_x    = {{(DW+1){signed_i & b_i[DW-1]}}, b_i};
    assign prod_o = a_x * b_x;

endmodule

// File: rtl/dot_product_mac.sv
// Streaming dot-product engine: LANES products per beat, DEPTH terms per result.
module dot_product_mac
    import dot_product_pkg::*;
#(
    parameter int DW    = 8,
    parameter int LANES = 4,
    parameter int DEPTH = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [LANES*DW-1:0]                 in_a,
    input  logic [LANES*DW-1:0]                 in_b,
    input  logic                                in_signed,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [acc_width(DW, DEPTH)-1:0]     out_data
);

    localparam int BEATS = DEPTH / LANES;
    localparam int ACC_W = acc_width(DW, DEPTH);
    localparam int PW    = 2 * DW + 1;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    dp_state_t                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      mode_q, mode_d;
    logic [LANES-1:0][PW-1:0]  prod;
    logic [LANES-1:0][PW-1:0]  p1_q;
    logic                      p1_vld_q;
    logic                      p1_first_q;
    logic [ACC_W-1:0]          acc_q, acc_d, tree_sum;
    logic [ACC_W-1:0]          out_data_q;
    logic                      beat;
    logic                      lane_signed;

    assign in_ready  = (state_q == IDLE) || (state_q == ACCUM);
    assign beat      = in_valid && in_ready;
    // First beat uses the live mode bit; later beats use the latched one.
    assign lane_signed = (state_q == IDLE) ? in_signed : mode_q;
    assign out_valid = (state_q == DONE);
    assign out_data  = out_data_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        dp_lane_mult #(.DW(DW)) u_mult (
            .a_i      (in_a[i*DW +: DW]),
            .b_i      (in_b[i*DW +: DW]),
            .signed_i (lane_signed),
            .prod_o   (prod[i])
        );
    end

    // Next-state logic: beat counting, mode latch, drain and output handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: if (beat) begin
                mode_d  = in_signed;
                cnt_d   = CNT_W'(1);
                state_d = (BEATS == 1) ? FLUSH : ACCUM;
            end
            ACCUM: if (beat) begin
                if (cnt_q == CNT_W'(BEATS - 1)) begin
                    cnt_d   = '0;
                    state_d = FLUSH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FLUSH:   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // P2: sign-extend and sum the registered lane products, then accumulate;
    // the first beat of a vector restarts the sum instead of adding to it.
    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            tree_sum = tree_sum + ACC_W'($signed(p1_q[i]));
        end
        acc_d = acc_q;
        if (p1_vld_q) begin
            acc_d = (p1_first_q ? '0 : acc_q) + tree_sum;
        end
    end

    // State, P1 product register, accumulator and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            p1_q       <= '0;
            p1_vld_q   <= 1'b0;
            p1_first_q <= 1'b0;
            acc_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            p1_vld_q   <= beat;
            p1_first_q <= beat && (state_q == IDLE);
            if (beat) p1_q <= prod;
            acc_q      <= acc_d;
            // The final beat finishes accumulating during FLUSH, so take acc_d.
            if (state_q == FLUSH) out_data_q <= acc_d;
        end
    end

endmodule

// File: doc/dot_product_mac.md
Name: dot_product_mac

Overview:
- Sequential, parametrised dot-product engine; the next generation of the single 8x8 combinational multiplier.
- Accepts LANES element pairs per beat over a valid/ready stream and accumulates DEPTH elements into one result.
- Supports a signed/unsigned mode per vector and presents the result on a valid/ready output.
- Sits between the operand-fetch buffers and the activation/result writeback path of the compute array.

Parameters:
- DW, 8, element width of a and b.
- LANES, 4, element pairs consumed per input beat; power of 2, at least 1.
- DEPTH, 8, elements per dot product; power of 2, multiple of LANES.
- BEATS, DEPTH/LANES, derived localparam: beats per vector.
- ACC_W, 2*DW+$clog2(DEPTH), derived localparam: result width; cannot overflow in either mode.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_a  in  LANES*DW  packed operands a; lane i is bits [i*DW +: DW].
- in_b  in  LANES*DW  packed operands b; same packing as in_a.
- in_signed  in  1  1 = two's-complement operands; sampled only on the first beat of a vector.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  ACC_W  dot product; two's complement when the vector is signed.

Behaviour:
- Reset: synchronous, active-high, as already decided. Values after reset:
  - out_valid=0, out_data=0, in_ready=1.
  - State IDLE; beat counter=0; accumulator=0; pipeline valid bits=0.
  - Reset mid-vector or with a result pending discards all partial and pending data.
- Beat transfer occurs when in_valid and in_ready are both high. Gaps in in_valid are legal anywhere within a vector.
- Arithmetic:
  - Each lane operand is sign- or zero-extended per the latched mode; product width is 2*DW+1.
  - Lane products are summed by an adder tree, then extended to ACC_W and added to the accumulator.
  - No saturation is needed: ACC_W is sized for the worst case.
- Pipeline:
  - P1 registers the lane products.
  - P2 performs the adder tree plus accumulate into the accumulator register.
  - Latency: last beat accepted at cycle T means out_valid=1 at T+2.
- FSM states:
  - IDLE: in_ready=1. On a beat: latch in_signed, clear the accumulator, set cnt=1, go to ACCUM. If BEATS==1, go to FLUSH instead.
  - ACCUM: in_ready=1. On each beat cnt++. When the beat is the final one (cnt==BEATS-1), go to FLUSH.
  - FLUSH: in_ready=0. Wait for the P1/P2 drain (fixed 1 cycle), then load out_data and go to DONE.
  - DONE: out_valid=1, in_ready=0, out_data held stable. When out_ready=1, go to IDLE and drop out_valid the next cycle.
- out_ready may already be high when out_valid rises; the handshake then completes in that same cycle.
- The next vector's first beat can be accepted on the cycle after the output handshake. Input and output phases do not overlap.
- in_signed on non-first beats is ignored.
- in_a and in_b are ignored when in_valid=0 or in_ready=0.
- Hold-stable rule: out_valid and out_data must not change while out_valid=1 and out_ready=0.

Decomposition:
- Package dot_product_pkg holds:
  - typedef enum dp_state_t {IDLE, ACCUM, FLUSH, DONE};
  - function acc_width(dw, depth) used to derive ACC_W.
- Sub-module dp_lane_mult: one DW x DW multiplier with a signed flag and (2*DW+1)-bit output. It is combinational, instantiated LANES times, and is the natural place to reuse the existing multiplier.
- The adder tree, accumulator and FSM stay in the top module.

Test Plan (LANES=4, DEPTH=8, DW=8 unless stated):
- Unsigned, all a=255 and b=255, 2 back-to-back beats -> out_data=520200, out_valid exactly 2 cycles after the second beat.
- Signed, all a=-128 and b=-128 -> out_data=131072. Then signed, all a=-128 and b=127 -> out_data=-130048 (19-bit two's complement).
- Unsigned, a=1..8 and b=1, with 3 idle cycles between beats -> out_data=36 and in_ready=1 throughout the gap.
- Backpressure: out_ready held low 5 cycles -> out_valid and out_data stable and in_ready=0. Raise out_ready -> one handshake, in_ready=1 the next cycle, and the next vector gives the correct independent result.
- Reset asserted after 1 beat of a vector -> out_valid=0 and in_ready=1 the following cycle. The next vector (a=2, b=3 all) -> 48, with no residue from before reset.
- in_signed=1 on beat 0 and 0 on beat 1, all a=0xFF and b=0x01 -> out_data=-8. Repeat with LANES=8, DEPTH=8 (BEATS=1) -> IDLE goes directly to FLUSH, same result.
